// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants, datapath typedefs and helper functions for the
// multi-port register file (regfile_mp) and its pending scoreboard.
//   DATA_WIDTH_DEF / ADDR_WIDTH_DEF : default register width and address width.
//   reg_addr_t / reg_data_t         : register address / data types at default sizes.
//   popcount()                      : number of set bits in a vector of up to
//                                     POPCOUNT_MAX_BITS bits (narrower vectors are
//                                     zero-padded by the caller).
package regfile_pkg;

    localparam int DATA_WIDTH_DEF    = 32;
    localparam int ADDR_WIDTH_DEF    = 5;

    // The popcount helper covers register files up to 256 entries (ADDR_WIDTH <= 8).
    localparam int POPCOUNT_MAX_BITS = 256;
    localparam int POPCOUNT_WIDTH    = 9;

    typedef logic [ADDR_WIDTH_DEF-1:0] reg_addr_t;
    typedef logic [DATA_WIDTH_DEF-1:0] reg_data_t;

    function automatic logic [POPCOUNT_WIDTH-1:0] popcount(
        input logic [POPCOUNT_MAX_BITS-1:0] vec
    );
        logic [POPCOUNT_WIDTH-1:0] count;
        count = {POPCOUNT_WIDTH{1'b0}};
        for (int b = 0; b < POPCOUNT_MAX_BITS; b++) begin
            count = count + {{(POPCOUNT_WIDTH-1){1'b0}}, vec[b]};
        end
        return count;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: decode/writeback-facing bus of the multi-port register file.
//   registerRead   : global read enable (0 forces every readValue to 0)
//   readAddress    : [READ_PORTS] read addresses
//   readValue      : [READ_PORTS] combinational read data (with write bypass)
//   readPending    : [READ_PORTS] addressed register still awaits its producer
//   registerWrite  : [WRITE_PORTS] per-port write enables (higher index wins)
//   writeAddress   : [WRITE_PORTS] write addresses
//   writeData      : [WRITE_PORTS] write data
//   reserveValid   : mark reserveAddress pending at the next edge
//   reserveAddress : register to reserve
//   pendingCount   : registered number of pending registers
// master = pipeline side driving requests, slave = the register file.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int READ_PORTS  = 2,
    parameter int WRITE_PORTS = 2
);

    logic                                     registerRead;
    logic [READ_PORTS-1:0][ADDR_WIDTH-1:0]    readAddress;
    logic [READ_PORTS-1:0][DATA_WIDTH-1:0]    readValue;
    logic [READ_PORTS-1:0]                    readPending;
    logic [WRITE_PORTS-1:0]                   registerWrite;
    logic [WRITE_PORTS-1:0][ADDR_WIDTH-1:0]   writeAddress;
    logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0]   writeData;
    logic                                     reserveValid;
    logic [ADDR_WIDTH-1:0]                    reserveAddress;
    logic [ADDR_WIDTH:0]                      pendingCount;

    modport master (
        output registerRead, readAddress, registerWrite, writeAddress, writeData,
               reserveValid, reserveAddress,
        input  readValue, readPending, pendingCount
    );

    modport slave (
        input  registerRead, readAddress, registerWrite, writeAddress, writeData,
               reserveValid, reserveAddress,
        output readValue, readPending, pendingCount
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: one pending bit per register for load-use hazard detection.
//   clk, rst       : clock, synchronous active-high reset
//   registerWrite  : [WRITE_PORTS] write enables (a write clears its address)
//   writeAddress   : [WRITE_PORTS] write addresses
//   reserveValid   : set the bit of reserveAddress (beats a same-cycle write)
//   reserveAddress : register being reserved
//   pending        : current pending vector, one bit per register
//   pendingCount   : registered popcount of the pending vector
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int WRITE_PORTS = 2,
    parameter bit ZERO_REG    = 1'b1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [WRITE_PORTS-1:0]                 registerWrite,
    input  logic [WRITE_PORTS-1:0][ADDR_WIDTH-1:0] writeAddress,
    input  logic                                   reserveValid,
    input  logic [ADDR_WIDTH-1:0]                  reserveAddress,
    output logic [(32'd1 << ADDR_WIDTH)-1:0]       pending,
    output logic [ADDR_WIDTH:0]                    pendingCount
);

    localparam int DEPTH = 32'd1 << ADDR_WIDTH;

    logic [DEPTH-1:0]             pending_r;
    logic [DEPTH-1:0]             nextPending_s;
    logic [POPCOUNT_MAX_BITS-1:0] paddedPending_s;
    logic [ADDR_WIDTH:0]          nextCount_s;
    logic [ADDR_WIDTH:0]          pendingCount_r;

    // Next pending vector: a reserve sets, a write clears, reserve has priority
    // because it represents a newer producer than the one now retiring.
    always_comb begin
        nextPending_s = pending_r;
        for (int k = 0; k < DEPTH; k++) begin
            logic reserveHit;
            logic writeHit;
            reserveHit = reserveValid && (reserveAddress == ADDR_WIDTH'(k))
                         && !(ZERO_REG && (k == 0));
            writeHit   = 1'b0;
            for (int p = 0; p < WRITE_PORTS; p++) begin
                writeHit = writeHit | (registerWrite[p] && (writeAddress[p] == ADDR_WIDTH'(k)));
            end
            if (reserveHit) begin
                nextPending_s[k] = 1'b1;
            end else if (writeHit) begin
                nextPending_s[k] = 1'b0;
            end else begin
                nextPending_s[k] = pending_r[k];
            end
        end
    end

    // Count is taken from the next-state vector so it lands on the same edge.
    always_comb begin
        paddedPending_s = {POPCOUNT_MAX_BITS{1'b0}};
        paddedPending_s[DEPTH-1:0] = nextPending_s;
        nextCount_s = (ADDR_WIDTH+1)'(popcount(paddedPending_s));
    end

    // Pending bits and count registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r      <= {DEPTH{1'b0}};
            pendingCount_r <= {(ADDR_WIDTH+1){1'b0}};
        end else begin
            pending_r      <= nextPending_s;
            pendingCount_r <= nextCount_s;
        end
    end

    assign pending      = pending_r;
    assign pendingCount = pendingCount_r;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with same-cycle write-to-read
// bypass and a pending scoreboard.
//   clk, rst : clock, synchronous active-high reset (clears array, pending, count)
//   bus      : regfile_mp_if slave port carrying read, write and reserve ports.
// Reads are combinational. An enabled write to the read address shows its data
// in the same cycle (highest-index write port wins); reset suppresses the bypass.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int READ_PORTS  = 2,
    parameter int WRITE_PORTS = 2,
    parameter bit ZERO_REG    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    regfile_mp_if.slave bus
);

    localparam int DEPTH = 32'd1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]  regArray_r [DEPTH];
    logic [DEPTH-1:0]       pending_s;
    logic [WRITE_PORTS-1:0] writeEnable_s;
    logic [DATA_WIDTH-1:0]  readValue_s [READ_PORTS];
    logic                   readPending_s [READ_PORTS];

    function automatic logic isZeroReg(input logic [ADDR_WIDTH-1:0] addr);
        return ZERO_REG && (addr == {ADDR_WIDTH{1'b0}});
    endfunction

    // Writes to the hardwired zero register never reach the array.
    for (genvar p = 0; p < WRITE_PORTS; p++) begin : g_write
        assign writeEnable_s[p] = bus.registerWrite[p] && !isZeroReg(bus.writeAddress[p]);
    end

    // Register array: ports are applied in ascending order, so the last
    // (highest-index) non-blocking update to a shared address wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                regArray_r[k] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            for (int p = 0; p < WRITE_PORTS; p++) begin
                if (writeEnable_s[p]) begin
                    regArray_r[bus.writeAddress[p]] <= bus.writeData[p];
                end
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .WRITE_PORTS (WRITE_PORTS),
        .ZERO_REG    (ZERO_REG)
    ) u_scoreboard (
        .clk            (clk),
        .rst            (rst),
        .registerWrite  (bus.registerWrite),
        .writeAddress   (bus.writeAddress),
        .reserveValid   (bus.reserveValid),
        .reserveAddress (bus.reserveAddress),
        .pending        (pending_s),
        .pendingCount   (bus.pendingCount)
    );

    for (genvar i = 0; i < READ_PORTS; i++) begin : g_read
        logic                  bypassHit_s;
        logic [DATA_WIDTH-1:0] bypassData_s;
        logic [ADDR_WIDTH-1:0] addr_s;

        assign addr_s = bus.readAddress[i];

        // Bypass search: later (higher-index) matching ports override earlier ones.
        always_comb begin
            bypassHit_s  = 1'b0;
            bypassData_s = {DATA_WIDTH{1'b0}};
            for (int p = 0; p < WRITE_PORTS; p++) begin
                bypassData_s = (bus.registerWrite[p] && (bus.writeAddress[p] == addr_s))
                               ? bus.writeData[p] : bypassData_s;
                bypassHit_s  = bypassHit_s
                               | (bus.registerWrite[p] && (bus.writeAddress[p] == addr_s));
            end
        end

        assign readValue_s[i] = (!bus.registerRead || isZeroReg(addr_s)) ? {DATA_WIDTH{1'b0}}
                              : (bypassHit_s && !rst)                    ? bypassData_s
                              :                                            regArray_r[addr_s];

        // A producer writing back this cycle resolves the hazard already.
        assign readPending_s[i] = pending_s[addr_s] && !bypassHit_s && !isZeroReg(addr_s);
    end

    // Pack per-port results onto the bus.
    always_comb begin
        bus.readValue   = {(READ_PORTS*DATA_WIDTH){1'b0}};
        bus.readPending = {READ_PORTS{1'b0}};
        for (int i = 0; i < READ_PORTS; i++) begin
            bus.readValue[i]   = readValue_s[i];
            bus.readPending[i] = readPending_s[i];
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int RP    = 2;
    localparam int WP    = 2;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst;
    always #10 clk = ~clk;

    regfile_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_PORTS(RP), .WRITE_PORTS(WP)) bus ();

    regfile_mp #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_PORTS(RP), .WRITE_PORTS(WP), .ZERO_REG(1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    reg_data_t mdl   [DEPTH];
    bit        mpend [DEPTH];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Highest-index enabled write port targeting address a, or -1.
    function automatic int winner(input int a);
        for (int p = WP - 1; p >= 0; p--) begin
            if (bus.registerWrite[p] && int'(bus.writeAddress[p]) == a) return p;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] expValue(input int i);
        int a = int'(bus.readAddress[i]);
        int w = winner(a);
        if (!bus.registerRead || a == 0) return 32'd0;
        if (!rst && w >= 0) return bus.writeData[w];
        return mdl[a];
    endfunction

    function automatic logic expPend(input int i);
        int a = int'(bus.readAddress[i]);
        return (a != 0) && mpend[a] && (winner(a) < 0);
    endfunction

    function automatic int pendSum();
        int s = 0;
        for (int a = 0; a < DEPTH; a++) s += int'(mpend[a]);
        return s;
    endfunction

    task automatic check_outputs();
        for (int i = 0; i < RP; i++) begin
            check($sformatf("readValue%0d", i), 64'(bus.readValue[i]), 64'(expValue(i)));
            check($sformatf("readPending%0d", i), 64'(bus.readPending[i]), 64'(expPend(i)));
        end
    endtask

    // Advance one edge, update the model from the inputs seen at that edge,
    // then check pendingCount on the falling edge.
    task automatic clock_edge();
        @(posedge clk);
        if (rst) begin
            for (int a = 0; a < DEPTH; a++) begin
                mdl[a]   = 32'd0;
                mpend[a] = 1'b0;
            end
        end else begin
            for (int a = 0; a < DEPTH; a++) begin
                int w = winner(a);
                if (a != 0 && w >= 0) mdl[a] = bus.writeData[w];
                if (bus.reserveValid && int'(bus.reserveAddress) == a && a != 0) mpend[a] = 1'b1;
                else if (w >= 0) mpend[a] = 1'b0;
            end
        end
        @(negedge clk);
        check("pendingCount", 64'(bus.pendingCount), 64'(pendSum()));
    endtask

    task automatic cycle();
        #1;
        check_outputs();
        clock_edge();
    endtask

    task automatic idle();
        bus.registerRead   = 1'b1;
        bus.readAddress    = '{default: 5'd0};
        bus.registerWrite  = 2'b00;
        bus.writeAddress   = '{default: 5'd0};
        bus.writeData      = '{default: 32'd0};
        bus.reserveValid   = 1'b0;
        bus.reserveAddress = 5'd0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        // First reset edge: array is unknown before it, so no comb checks yet.
        @(posedge clk);
        for (int a = 0; a < DEPTH; a++) begin
            mdl[a]   = 32'd0;
            mpend[a] = 1'b0;
        end
        @(negedge clk);
        check("count_after_reset", 64'(bus.pendingCount), 64'd0);
        bus.readAddress[0] = 5'd12;
        cycle();                                  // second reset edge
        rst = 1'b0;

        // 1. Reset and zero register
        idle();
        bus.registerWrite = 2'b11;
        bus.writeAddress[0] = 5'd12; bus.writeData[0] = 32'd1234;
        bus.writeAddress[1] = 5'd0;  bus.writeData[1] = 32'd1234;
        cycle();
        idle();
        bus.readAddress[0] = 5'd12; bus.readAddress[1] = 5'd0;
        #1;
        check("read_reg12", 64'(bus.readValue[0]), 64'd1234);
        check("read_reg0", 64'(bus.readValue[1]), 64'd0);
        check("count_t1", 64'(bus.pendingCount), 64'd0);
        cycle();

        // 2. Bypass and read gating
        idle();
        bus.registerWrite[0] = 1'b1; bus.writeAddress[0] = 5'd5; bus.writeData[0] = 32'hFFF785DD;
        bus.readAddress[0] = 5'd5; bus.readAddress[1] = 5'd12;
        #1;
        check("bypass_neg", 64'(bus.readValue[0]), 64'h0000_0000_FFF7_85DD);
        bus.registerRead = 1'b0;
        #1;
        check("gated0", 64'(bus.readValue[0]), 64'd0);
        check("gated1", 64'(bus.readValue[1]), 64'd0);
        cycle();

        // 3. Write conflict
        idle();
        bus.registerWrite = 2'b11;
        bus.writeAddress[0] = 5'd7; bus.writeData[0] = 32'h0000AAAA;
        bus.writeAddress[1] = 5'd7; bus.writeData[1] = 32'h00005555;
        bus.readAddress[0] = 5'd7;
        #1;
        check("conflict_bypass", 64'(bus.readValue[0]), 64'h5555);
        cycle();
        idle();
        bus.readAddress[1] = 5'd7;
        #1;
        check("conflict_stored", 64'(bus.readValue[1]), 64'h5555);
        cycle();

        // 4. Scoreboard life cycle
        idle();
        bus.reserveValid = 1'b1; bus.reserveAddress = 5'd3;
        cycle();
        idle();
        bus.readAddress[0] = 5'd3;
        #1;
        check("pend_reg3", 64'(bus.readPending[0]), 64'd1);
        check("count_reserve3", 64'(bus.pendingCount), 64'd1);
        bus.registerWrite[1] = 1'b1; bus.writeAddress[1] = 5'd3; bus.writeData[1] = 32'd42;
        #1;
        check("pend_reg3_bypass", 64'(bus.readPending[0]), 64'd0);
        cycle();
        check("count_cleared3", 64'(bus.pendingCount), 64'd0);

        // 5. Reserve/write collision
        idle();
        bus.reserveValid = 1'b1; bus.reserveAddress = 5'd9;
        bus.registerWrite[0] = 1'b1; bus.writeAddress[0] = 5'd9; bus.writeData[0] = 32'd77;
        cycle();
        idle();
        bus.readAddress[0] = 5'd9;
        #1;
        check("collide_value", 64'(bus.readValue[0]), 64'd77);
        check("collide_pend", 64'(bus.readPending[0]), 64'd1);
        check("collide_count", 64'(bus.pendingCount), 64'd1);
        bus.reserveValid = 1'b1; bus.reserveAddress = 5'd0;
        cycle();
        check("reserve0_count", 64'(bus.pendingCount), 64'd1);

        // 6. Reset mid-operation
        idle();
        bus.reserveValid = 1'b1; bus.reserveAddress = 5'd3;
        cycle();
        check("two_pending", 64'(bus.pendingCount), 64'd2);
        idle();
        rst = 1'b1;
        bus.registerWrite[0] = 1'b1; bus.writeAddress[0] = 5'd12; bus.writeData[0] = 32'd99;
        bus.readAddress[0] = 5'd12;
        #1;
        check("rst_no_bypass", 64'(bus.readValue[0]), 64'd1234);
        cycle();
        rst = 1'b0;
        idle();
        bus.readAddress[0] = 5'd12; bus.readAddress[1] = 5'd3;
        #1;
        check("rst_reg12", 64'(bus.readValue[0]), 64'd0);
        check("rst_pend3", 64'(bus.readPending[1]), 64'd0);
        check("rst_count", 64'(bus.pendingCount), 64'd0);
        bus.readAddress[1] = 5'd9;
        #1;
        check("rst_pend9", 64'(bus.readPending[1]), 64'd0);
        cycle();

        // Randomized traffic against the model; addresses biased to collide.
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 39) == 0);
            bus.registerRead = ($urandom_range(0, 7) != 0);
            for (int i = 0; i < RP; i++) bus.readAddress[i] = 5'($urandom_range(0, 9));
            for (int p = 0; p < WP; p++) begin
                bus.registerWrite[p] = 1'($urandom_range(0, 1));
                bus.writeAddress[p]  = 5'($urandom_range(0, 9));
                bus.writeData[p]     = $urandom;
            end
            bus.reserveValid   = 1'($urandom_range(0, 1));
            bus.reserveAddress = 5'($urandom_range(0, 9));
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
